dm_responder: RTL and testbench

Multi-cycle data-memory responder: the memory-side end of the CPU's data-access interface. It accepts one load/store request at a time over a req/ready handshake, inserts a configurable number of wait states, and applies byte-enable lane masking on writes and reads. It also flags illegal lane patterns and out-of-range addresses. It sits between the multicycle core's data-access path and a word-organised storage array, replacing the single-cycle data memory when memory latency must be modelled.

---
 rtl/dm_responder_pkg.sv | 44 ++++
 rtl/dm_be_check.sv | 17 +
 rtl/dm_responder.sv | 138 +++++++++++++
 tb/tb_dm_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, byte-enable
// patterns, the latched request record and lane helpers.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dm_state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    typedef struct packed {
        logic        we;
        logic [29:0] word;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dm_req_t;

    function automatic logic be_is_legal(input logic [3:0] be);
        logic legal;
        case (be)
            BE_WORD, BE_HALF_LO, BE_HALF_HI,
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dm_be_check.sv
// Byte-enable validator: flags illegal lane patterns and expands the enables
// into a 32-bit lane mask shared by the write and read paths.
module dm_be_check
    import dm_responder_pkg::*;
(
    input  logic [3:0]  be,
    output logic        legal,
    output logic [31:0] mask
);

    // Pure decode of the enable pattern.
    always_comb begin
        legal = be_is_legal(be);
        mask  = be_to_mask(be);
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait
// states, lane-masked stores and loads, illegal-lane and out-of-range rejection.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);
    localparam logic        ZERO_WAIT   = (WAIT_CYCLES == 0);

    dm_state_e        state_r;
    logic [3:0]       cnt_r;
    dm_req_t          req_r;
    dm_req_t          src_s;
    logic             ready_r;
    logic             err_r;
    logic             busy_r;
    logic [31:0]      rdata_r;
    logic [31:0]      mem_r [DEPTH];
    logic             be_legal_s;
    logic             in_range_s;
    logic             resp_err_s;
    logic             enter_resp_s;
    logic             commit_s;
    logic [31:0]      lane_mask_s;
    logic [31:0]      rd_word_s;
    logic [31:0]      resp_data_s;
    logic [IDX_W-1:0] idx_s;
    logic [1:0]       addr_unused_s;

    assign addr_unused_s = addr[1:0];

    // With zero wait states the response is formed on the accept edge, so the
    // live inputs are used there; otherwise only the latched copy matters.
    always_comb begin
        src_s = req_r;
        if (state_r == IDLE) begin
            src_s.we    = we;
            src_s.word  = addr[31:2];
            src_s.be    = be;
            src_s.wdata = wdata;
        end else begin
            src_s = req_r;
        end
    end

    dm_be_check u_be_check (
        .be    (src_s.be),
        .legal (be_legal_s),
        .mask  (lane_mask_s)
    );

    // Response formation and the RESP-entry condition.
    always_comb begin
        in_range_s   = (src_s.word < DEPTH_WORDS);
        idx_s        = src_s.word[IDX_W-1:0];
        resp_err_s   = ~(be_legal_s & in_range_s);
        rd_word_s    = mem_r[idx_s];
        resp_data_s  = (resp_err_s | src_s.we) ? 32'h0000_0000 : (rd_word_s & lane_mask_s);
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE:    enter_resp_s = req & ZERO_WAIT;
            WAIT:    enter_resp_s = (cnt_r == 4'd1);
            default: enter_resp_s = 1'b0;
        endcase
        commit_s = rst & enter_resp_s & src_s.we & ~resp_err_s;
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            req_r   <= '0;
            ready_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req) begin
                        req_r   <= src_s;
                        cnt_r   <= WAIT_INIT;
                        busy_r  <= 1'b1;
                        state_r <= ZERO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            ready_r <= enter_resp_s;
            rdata_r <= enter_resp_s ? resp_data_s : 32'h0000_0000;
            err_r   <= enter_resp_s ? resp_err_s : 1'b0;
        end
    end

    // Storage array deliberately has no reset; only enabled lanes are merged in.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= (rd_word_s & ~lane_mask_s) | (src_s.wdata & lane_mask_s);
        end
    end

    assign ready = ready_r;
    assign rdata = rdata_r;
    assign err   = err_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: three instances (2, 0 and 15 wait
// states) against a transaction-level model, plus directed literal checks.
module tb_dm_responder;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        req_s   [3];
    logic        ready_s [3];
    logic        err_s   [3];
    logic        busy_s  [3];
    logic [31:0] rdata_s [3];

    int wc [3] = '{2, 0, 15};
    int checks = 0;
    int errors = 0;

    // Model state: per instance, whether a transaction is open and how many
    // edges remain until its response cycle, plus the expected response.
    logic [31:0] mdl_mem [int];
    bit          m_busy  [3];
    int          m_left  [3];
    bit          m_we    [3];
    logic [31:0] m_addr  [3];
    logic [3:0]  m_be    [3];
    logic [31:0] m_wdata [3];
    logic [31:0] m_rdata [3];
    bit          m_err   [3];

    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .req(req_s[0]), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready_s[0]), .rdata(rdata_s[0]), .err(err_s[0]), .busy(busy_s[0]));
    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .req(req_s[1]), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready_s[1]), .rdata(rdata_s[1]), .err(err_s[1]), .busy(busy_s[1]));
    dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst(rst), .req(req_s[2]), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready_s[2]), .rdata(rdata_s[2]), .err(err_s[2]), .busy(busy_s[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic bit be_ok(input logic [3:0] b);
        return b inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) m = m | (32'h0000_00FF << (8 * i));
        end
        return m;
    endfunction

    // Resolve a transaction at the moment its response becomes visible.
    function automatic void mdl_resolve(input int k);
        logic [31:0] mask;
        logic [31:0] cur;
        int          key;
        mask = lane_mask(m_be[k]);
        if (!be_ok(m_be[k]) || m_addr[k][31:2] >= 30'(DEPTH)) begin
            m_err[k]   = 1'b1;
            m_rdata[k] = 32'h0;
        end else begin
            key = k * DEPTH + int'(m_addr[k][31:2]);
            cur = mdl_mem.exists(key) ? mdl_mem[key] : 32'h0;
            m_err[k] = 1'b0;
            if (m_we[k]) begin
                mdl_mem[key] = (cur & ~mask) | (m_wdata[k] & mask);
                m_rdata[k]   = 32'h0;
            end else begin
                m_rdata[k] = cur & mask;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 1'b0;
                m_left[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_busy[k]) begin
                    if (m_left[k] == 0) begin
                        m_busy[k] = 1'b0;
                    end else begin
                        m_left[k] = m_left[k] - 1;
                        if (m_left[k] == 0) mdl_resolve(k);
                    end
                end else if (req_s[k]) begin
                    m_we[k]    = we;
                    m_addr[k]  = addr;
                    m_be[k]    = be;
                    m_wdata[k] = wdata;
                    m_busy[k]  = 1'b1;
                    m_left[k]  = wc[k];
                    if (wc[k] == 0) mdl_resolve(k);
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy[%0d]", k), 32'(busy_s[k]), 32'(m_busy[k]));
            chk($sformatf("ready[%0d]", k), 32'(ready_s[k]), 32'(m_busy[k] && m_left[k] == 0));
            if (m_busy[k] && m_left[k] == 0) begin
                chk($sformatf("rdata[%0d]", k), rdata_s[k], m_rdata[k]);
                chk($sformatf("err[%0d]", k), 32'(err_s[k]), 32'(m_err[k]));
            end
        end
    end

    // Issue one request right after a rising edge and wait for its response.
    task automatic do_req(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output logic [31:0] rd, output logic e,
                          output int lat);
        req_s[k] = 1'b1;
        we       = w;
        addr     = a;
        be       = b;
        wdata    = d;
        @(posedge clk); #1;
        req_s[k] = 1'b0;
        lat = 0;
        while (!ready_s[k] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_s[k];
        e  = err_s[k];
        @(posedge clk); #1;
        chk("noDouble", 32'(ready_s[k]), 32'h0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;

    initial begin
        rst   = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        be    = 4'h0;
        wdata = 32'h0;
        for (int k = 0; k < 3; k++) req_s[k] = 1'b0;
        #7;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", 32'(ready_s[k]), 32'h0);
            chk("rst_busy", 32'(busy_s[k]), 32'h0);
            chk("rst_err", 32'(err_s[k]), 32'h0);
            chk("rst_rdata", rdata_s[k], 32'h0);
        end
        #5 rst = 1'b1;
        @(posedge clk); #1;

        do_req(0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, rd, e, lat);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_err", 32'(e), 32'h0);
        chk("st_rdata", rd, 32'h0);
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
        chk("ld_lat", 32'(lat), 32'd2);
        chk("ld_rdata", rd, 32'hDEAD_BEEF);
        chk("ld_err", 32'(e), 32'h0);

        do_req(0, 1'b1, 32'h20, 4'b1111, 32'h1122_3344, rd, e, lat);
        do_req(0, 1'b1, 32'h20, 4'b0100, 32'h00AA_0000, rd, e, lat);
        do_req(0, 1'b0, 32'h20, 4'b1111, 32'h0, rd, e, lat);
        chk("merge_word", rd, 32'h11AA_3344);
        do_req(0, 1'b0, 32'h20, 4'b1100, 32'h0, rd, e, lat);
        chk("merge_hi", rd, 32'h11AA_0000);
        do_req(0, 1'b0, 32'h20, 4'b0010, 32'h0, rd, e, lat);
        chk("merge_b1", rd, 32'h0000_3300);

        do_req(0, 1'b1, 32'h10, 4'b0110, 32'hFFFF_FFFF, rd, e, lat);
        chk("illbe_err", 32'(e), 32'h1);
        chk("illbe_rdata", rd, 32'h0);
        do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, e, lat);
        chk("zerobe_err", 32'(e), 32'h1);
        do_req(0, 1'b1, 32'h0, 4'b1111, 32'h0BAD_F00D, rd, e, lat);
        do_req(0, 1'b1, 32'h1000, 4'b1111, 32'hFFFF_FFFF, rd, e, lat);
        chk("oor_st_err", 32'(e), 32'h1);
        do_req(0, 1'b0, 32'h1000, 4'b1111, 32'h0, rd, e, lat);
        chk("oor_ld_err", 32'(e), 32'h1);
        chk("oor_ld_rdata", rd, 32'h0);
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
        chk("keep_10", rd, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 32'h0, 4'b1111, 32'h0, rd, e, lat);
        chk("keep_00", rd, 32'h0BAD_F00D);

        do_req(0, 1'b1, 32'h30, 4'b1111, 32'h0, rd, e, lat);
        req_s[0] = 1'b1;
        we       = 1'b1;
        addr     = 32'h30;
        be       = 4'b1111;
        wdata    = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        chk("abort_busy_pre", 32'(busy_s[0]), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_s[0]), 32'h0);
        chk("abort_ready", 32'(ready_s[0]), 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'h30, 4'b1111, 32'h0, rd, e, lat);
        chk("abort_nowrite", rd, 32'h0);

        req_s[1] = 1'b1;
        we       = 1'b1;
        addr     = 32'h40;
        be       = 4'b1111;
        wdata    = 32'h1234_5678;
        @(posedge clk); #1;
        chk("w0_ready", 32'(ready_s[1]), 32'h1);
        chk("w0_busy", 32'(busy_s[1]), 32'h1);
        wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("w0_idle_ready", 32'(ready_s[1]), 32'h0);
        chk("w0_idle_busy", 32'(busy_s[1]), 32'h0);
        we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("w0_pulse", 32'(ready_s[1]), 32'h1);
            chk("w0_rdata", rdata_s[1], 32'h1234_5678);
            @(posedge clk); #1;
            chk("w0_gap", 32'(ready_s[1]), 32'h0);
            chk("w0_gap_busy", 32'(busy_s[1]), 32'h0);
        end
        req_s[1] = 1'b0;
        @(posedge clk); #1;

        do_req(2, 1'b1, 32'h50, 4'b1111, 32'h1234_BEEF, rd, e, lat);
        chk("w15_st_lat", 32'(lat), 32'd15);
        do_req(2, 1'b0, 32'h50, 4'b0011, 32'h0, rd, e, lat);
        chk("w15_ld_lat", 32'(lat), 32'd15);
        chk("w15_rdata", rd, 32'h0000_BEEF);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
